spi_slave_shifter: RTL and testbench
====================================

Name: spi_slave_shifter

Overview:
- SPI slave-side serial engine; the counterpart to the master SCLK generator.
- Oversamples an external SCLK/SS_N/MOSI in the i_clk domain, detects SCLK edges, samples MOSI and drives MISO per CPOL/CPHA.
- Transfers DATA_W-bit words.
- Sits between the SPI pins and the register/AXI side: single-entry TX holding register with ready/valid, RX word strobe.

Parameters:
- DATA_W, 8, word width in bits (>=2).
- SYNC_STAGES, 2, flip-flop stages on i_sclk, i_ss_n and i_mosi (>=2).

Ports:
- i_clk  in  1  system clock; must be at least 8x the SCLK frequency.
- i_reset  in  1  synchronous, active-high reset.
- i_spi_en  in  1  slave mode enable (register SPE & !MSTR).
- i_cpol  in  1  clock polarity.
- i_cpha  in  1  clock phase.
- i_sclk  in  1  external SPI clock, asynchronous.
- i_ss_n  in  1  slave select, active low, asynchronous.
- i_mosi  in  1  master-out data, asynchronous.
- o_miso  out  1  slave-out data.
- o_miso_oe  out  1  MISO pad output enable.
- i_tx_data  in  DATA_W  next word to transmit.
- i_tx_valid  in  1  TX write request.
- o_tx_ready  out  1  holding register empty.
- o_rx_data  out  DATA_W  last complete received word.
- o_rx_valid  out  1  one-cycle strobe: o_rx_data updated.
- o_tx_underrun  out  1  one-cycle strobe: word load found holding register empty.
- o_busy  out  1  slave selected and active.

Behaviour:
- Reset values:
  - all outputs 0, except o_tx_ready = 1;
  - synchronizers: sclk 0, ss_n 1, mosi 0;
  - bit_cnt 0, state IDLE.
- Edge detect:
  - sclk_s = last sync stage; sclk_d = sclk_s delayed one cycle.
  - Rising edge = sclk_s & !sclk_d; falling edge = !sclk_s & sclk_d.
- Edge roles:
  - Sample edge = rising for {cpol,cpha} = 00 or 11, falling for 01 or 10.
  - Setup edge = the other edge.
- FSM IDLE:
  - o_busy = 0, o_miso_oe = 0, edges ignored.
  - On synchronized ss_n falling edge with i_spi_en = 1: go ACTIVE, bit_cnt = 0.
  - If cpha = 0, load the TX word immediately (word-load rule below).
- FSM ACTIVE:
  - o_busy = 1, o_miso_oe = 1, o_miso = tx_shift[DATA_W-1].
  - Sample edge: rx_shift <= {rx_shift[DATA_W-2:0], mosi_s}; bit_cnt++.
  - When bit_cnt reaches DATA_W: o_rx_data <= the completed word the next cycle, o_rx_valid pulses 1 cycle, bit_cnt wraps to 0.
  - Setup edge with bit_cnt == 0: word load. With bit_cnt != 0: tx_shift <= tx_shift << 1.
  - The cpha = 0 setup edge following the last sample edge therefore loads the next word; back-to-back words need no gap.
- Word load:
  - Holding full: tx_shift <= holding, holding becomes empty, o_tx_ready = 1.
  - Holding empty: tx_shift <= 0, o_tx_underrun pulses.
- TX handshake:
  - Write accepted when i_tx_valid & o_tx_ready; o_tx_ready drops the next cycle.
  - A write in the same cycle as a word load: the load consumes the old content (or underruns), and the new word is stored.
- Latency: o_rx_valid asserts SYNC_STAGES+2 i_clk cycles after the final sample edge at the pin.
- Deselect mid-word (ss_n rises) or i_spi_en drops:
  - Return to IDLE the next cycle; bit_cnt = 0.
  - Partial word discarded; no o_rx_valid.
  - Word already in tx_shift is lost; holding register is kept.
- Simultaneous ss_n fall and SCLK edge: the edge is ignored.
- i_cpol/i_cpha changes while ACTIVE: undefined; software changes them only in IDLE.
- Reset mid-transfer: immediate return to reset values; holding contents lost.

Optional Feature:
- Macro: SPI_SLAVE_LSB_FIRST_EN.
- Defined:
  - Adds input port i_lsbfe (1 bit).
  - When i_lsbfe = 1: o_miso = tx_shift[0], shifts are right shifts, and RX inserts mosi_s at the MSB and shifts right, so the first received bit lands in bit 0.
- Undefined: port absent; always MSB-first.

Test Plan:
- Mode 0 (cpol 0, cpha 0), SCLK = i_clk/8; preload 0x3C; master sends 0xA5 -> MISO bits 0,0,1,1,1,1,0,0; o_rx_data = 0xA5 with a single o_rx_valid pulse; o_tx_ready returns 1 at select.
- Mode 3, two back-to-back words; holding 0x81, then 0x7E written during the first word; master sends 0x12, 0x34 -> MISO 0x81 then 0x7E; two rx strobes with 0x12 then 0x34; no underrun.
- Mode 1, no TX preload; master sends 0xFF -> MISO all 0; o_tx_underrun pulses once; o_rx_data = 0xFF.
- Mode 2; ss_n deasserted after 5 bits, then a full word 0x5A -> no strobe for the partial word; the subsequent word gives o_rx_data = 0x5A; o_miso_oe = 0 while deselected.
- Assert i_reset mid-word, then i_spi_en = 0 with ss_n low -> all outputs at reset values; no strobes; o_busy stays 0.
- With SPI_SLAVE_LSB_FIRST_EN and i_lsbfe = 1, mode 0; preload 0x01; master sends 0x80 LSB-first -> MISO first bit 1; o_rx_data = 0x80.

Source files
------------

// File: rtl/spi_slave_shifter.sv
// spi_slave_shifter: SPI slave serial engine.
// Oversamples the asynchronous SCLK / SS_N / MOSI pins in the i_clk domain,
// finds SCLK edges, shifts MOSI into an RX word and drives MISO from a TX
// shift register fed by a single-entry holding register (ready/valid).
// Optional build macro: SPI_SLAVE_LSB_FIRST_EN adds i_lsbfe for LSB-first
// transfers; without it every transfer is MSB-first.
module spi_slave_shifter #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_spi_en,
    input  logic              i_cpol,
    input  logic              i_cpha,
`ifdef SPI_SLAVE_LSB_FIRST_EN
    input  logic              i_lsbfe,
`endif
    input  logic              i_sclk,
    input  logic              i_ss_n,
    input  logic              i_mosi,
    output logic              o_miso,
    output logic              o_miso_oe,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_tx_underrun,
    output logic              o_busy
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    // Bit order {mosi, ss_n, sclk}; idle levels after reset are mosi 0, ss_n 1, sclk 0.
    localparam logic [2:0] SYNC_RST = 3'b010;

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [2:0]        pin_vec;
    logic [2:0]        sync_s;
    logic              sclk_s, ss_s, mosi_s;

    state_t            state_reg;
    logic              sclk_d_reg;
    logic              ss_d_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [DATA_W-1:0] tx_shift_reg;
    logic [DATA_W-1:0] rx_shift_reg;
    logic [DATA_W-1:0] hold_reg;
    logic              hold_full_reg;
    logic              rx_done_reg;

    logic              lsb_mode;
    logic              rise_edge, fall_edge;
    logic              sample_edge, setup_edge;
    logic              ss_fall;
    logic              stay_selected;
    logic              load_req;
    logic              tx_write;
    logic              last_bit;

    assign pin_vec = {i_mosi, i_ss_n, i_sclk};

    // One synchronizer chain per asynchronous pin.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;

            // Shift the pin level through SYNC_STAGES flops.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    chain_reg <= {SYNC_STAGES{SYNC_RST[gi]}};
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin_vec[gi]};
                end
            end

            assign sync_s[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    assign sclk_s = sync_s[0];
    assign ss_s   = sync_s[1];
    assign mosi_s = sync_s[2];

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign lsb_mode = i_lsbfe;
`else
    assign lsb_mode = 1'b0;
`endif

    // Edge roles: modes 0 and 3 sample on rising SCLK, modes 1 and 2 on falling.
    assign rise_edge   = sclk_s & ~sclk_d_reg;
    assign fall_edge   = ~sclk_s & sclk_d_reg;
    assign sample_edge = (i_cpol ^ i_cpha) ? fall_edge : rise_edge;
    assign setup_edge  = (i_cpol ^ i_cpha) ? rise_edge : fall_edge;
    assign ss_fall     = ~ss_s & ss_d_reg;

    assign stay_selected = ~ss_s & i_spi_en;
    assign last_bit      = (bit_cnt_reg == CNT_W'(DATA_W - 1));
    assign tx_write      = i_tx_valid & ~hold_full_reg;

    // Word load: at select for cpha=0, otherwise on a setup edge at a word boundary.
    assign load_req = ((state_reg == IDLE) && ss_fall && i_spi_en && !i_cpha) ||
                      ((state_reg == ACTIVE) && stay_selected && setup_edge &&
                       (bit_cnt_reg == '0));

    // Control FSM, shift registers, holding register and strobes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg     <= IDLE;
            sclk_d_reg    <= 1'b0;
            ss_d_reg      <= 1'b1;
            bit_cnt_reg   <= '0;
            tx_shift_reg  <= '0;
            rx_shift_reg  <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            rx_done_reg   <= 1'b0;
            o_rx_data     <= '0;
            o_rx_valid    <= 1'b0;
            o_tx_underrun <= 1'b0;
        end else begin
            sclk_d_reg    <= sclk_s;
            ss_d_reg      <= ss_s;
            rx_done_reg   <= 1'b0;
            o_rx_valid    <= 1'b0;
            o_tx_underrun <= 1'b0;

            // A completed word is published one cycle after its last sample.
            if (rx_done_reg) begin
                o_rx_data  <= rx_shift_reg;
                o_rx_valid <= 1'b1;
            end

            // The load consumes the old holding content before a same-cycle write lands.
            if (load_req) begin
                if (hold_full_reg) begin
                    tx_shift_reg <= hold_reg;
                end else begin
                    tx_shift_reg  <= '0;
                    o_tx_underrun <= 1'b1;
                end
            end

            if (tx_write) begin
                hold_reg      <= i_tx_data;
                hold_full_reg <= 1'b1;
            end else if (load_req) begin
                hold_full_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (ss_fall && i_spi_en) begin
                        state_reg   <= ACTIVE;
                        bit_cnt_reg <= '0;
                    end
                end
                ACTIVE: begin
                    if (!stay_selected) begin
                        // Partial word is dropped; holding register survives.
                        state_reg   <= IDLE;
                        bit_cnt_reg <= '0;
                    end else begin
                        if (sample_edge) begin
                            if (lsb_mode) begin
                                rx_shift_reg <= {mosi_s, rx_shift_reg[DATA_W-1:1]};
                            end else begin
                                rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], mosi_s};
                            end
                            if (last_bit) begin
                                bit_cnt_reg <= '0;
                                rx_done_reg <= 1'b1;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                            end
                        end
                        if (setup_edge && (bit_cnt_reg != '0)) begin
                            if (lsb_mode) begin
                                tx_shift_reg <= tx_shift_reg >> 1;
                            end else begin
                                tx_shift_reg <= tx_shift_reg << 1;
                            end
                        end
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    bit_cnt_reg <= '0;
                end
            endcase
        end
    end

    assign o_busy     = (state_reg == ACTIVE);
    assign o_miso_oe  = (state_reg == ACTIVE);
    assign o_miso     = (state_reg == ACTIVE) &
                        (lsb_mode ? tx_shift_reg[0] : tx_shift_reg[DATA_W-1]);
    assign o_tx_ready = ~hold_full_reg;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// tb_spi_slave_shifter: directed bench acting as SPI master (SCLK = clk/8)
// and as the register-side writer; counts strobes with a negedge monitor.
`timescale 1ns/1ps
module tb_spi_slave_shifter;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_en, cpol, cpha;
    logic       sclk, ss_n, mosi;
    logic       miso, miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, underrun, busy;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    logic       lsbfe;
`endif

    int n_vec = 0;
    int n_err = 0;
    int rx_cnt = 0;
    int ur_cnt = 0;
    int busy_cnt = 0;
    logic [7:0] rx_log [0:31];

    always #5 clk = ~clk;

    spi_slave_shifter #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_spi_en      (spi_en),
        .i_cpol        (cpol),
        .i_cpha        (cpha),
`ifdef SPI_SLAVE_LSB_FIRST_EN
        .i_lsbfe       (lsbfe),
`endif
        .i_sclk        (sclk),
        .i_ss_n        (ss_n),
        .i_mosi        (mosi),
        .o_miso        (miso),
        .o_miso_oe     (miso_oe),
        .i_tx_data     (tx_data),
        .i_tx_valid    (tx_valid),
        .o_tx_ready    (tx_ready),
        .o_rx_data     (rx_data),
        .o_rx_valid    (rx_valid),
        .o_tx_underrun (underrun),
        .o_busy        (busy)
    );

    // Monitor: log every strobe and busy cycle, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt[4:0]] = rx_data;
            rx_cnt = rx_cnt + 1;
        end
        if (underrun) ur_cnt = ur_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    // Master side of one word, MSB first, nbits bits; returns the MISO bits seen.
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = mo[7-i];
                tick(4);
                mi[7-i] = miso;
                sclk = ~sclk;
                tick(4);
                sclk = ~sclk;
            end else begin
                sclk = ~sclk;
                mosi = mo[7-i];
                tick(4);
                mi[7-i] = miso;
                sclk = ~sclk;
                tick(4);
            end
        end
    endtask

    logic [7:0] mi1, mi2;
    int rx_base, ur_base, busy_base;

    initial begin
        reset = 1'b1; spi_en = 1'b0; cpol = 1'b0; cpha = 1'b0;
        sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0;
`ifdef SPI_SLAVE_LSB_FIRST_EN
        lsbfe = 1'b0;
`endif
        tick(3);
        // Reset state
        check("rst_miso",     32'(miso),     32'd0);
        check("rst_miso_oe",  32'(miso_oe),  32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_data",  32'(rx_data),  32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        reset = 1'b0;
        spi_en = 1'b1;
        tick(4);

        // Mode 0: preload 0x3C, master sends 0xA5
        tx_write(8'h3C);
        check("m0_ready_drop", 32'(tx_ready), 32'd0);
        rx_base = rx_cnt; ur_base = ur_cnt;
        ss_n = 1'b0;
        tick(8);
        check("m0_ready_sel", 32'(tx_ready), 32'd1);
        check("m0_busy",      32'(busy),     32'd1);
        check("m0_oe",        32'(miso_oe),  32'd1);
        xfer(8'hA5, 8, mi1);
        tick(8);
        check("m0_miso_word", 32'(mi1), 32'h3C);
        check("m0_rx_count",  32'(rx_cnt - rx_base), 32'd1);
        check("m0_rx_data",   32'(rx_data), 32'hA5);
        // Trailing setup edge after the last bit finds the holding register empty.
        check("m0_underrun",  32'(ur_cnt - ur_base), 32'd1);
        ss_n = 1'b1;
        tick(8);
        check("m0_busy_off",  32'(busy), 32'd0);

        // Mode 3: back-to-back words, second TX word written mid-transfer
        cpol = 1'b1; cpha = 1'b1; sclk = 1'b1;
        tick(8);
        tx_write(8'h81);
        rx_base = rx_cnt; ur_base = ur_cnt;
        ss_n = 1'b0;
        tick(8);
        fork
            xfer(8'h12, 8, mi1);
            begin
                tick(20);
                check("m3_ready_mid", 32'(tx_ready), 32'd1);
                tx_write(8'h7E);
            end
        join
        xfer(8'h34, 8, mi2);
        tick(8);
        check("m3_miso_w0",  32'(mi1), 32'h81);
        check("m3_miso_w1",  32'(mi2), 32'h7E);
        check("m3_rx_count", 32'(rx_cnt - rx_base), 32'd2);
        check("m3_rx_w0",    32'(rx_log[rx_base[4:0]]), 32'h12);
        check("m3_rx_w1",    32'(rx_log[5'(rx_base + 1)]), 32'h34);
        check("m3_underrun", 32'(ur_cnt - ur_base), 32'd0);
        ss_n = 1'b1;
        tick(8);

        // Mode 1: nothing preloaded, master sends 0xFF
        cpol = 1'b0; cpha = 1'b1; sclk = 1'b0;
        tick(8);
        rx_base = rx_cnt; ur_base = ur_cnt;
        ss_n = 1'b0;
        tick(8);
        xfer(8'hFF, 8, mi1);
        tick(8);
        check("m1_miso_word", 32'(mi1), 32'h00);
        check("m1_underrun",  32'(ur_cnt - ur_base), 32'd1);
        check("m1_rx_count",  32'(rx_cnt - rx_base), 32'd1);
        check("m1_rx_data",   32'(rx_data), 32'hFF);
        ss_n = 1'b1;
        tick(8);

        // Mode 2: 5-bit partial word, deselect, then full word 0x5A
        cpol = 1'b1; cpha = 1'b0; sclk = 1'b1;
        tick(8);
        rx_base = rx_cnt;
        ss_n = 1'b0;
        tick(8);
        xfer(8'hFF, 5, mi1);
        tick(2);
        ss_n = 1'b1;
        tick(8);
        check("m2_partial_rx", 32'(rx_cnt - rx_base), 32'd0);
        check("m2_oe_desel",   32'(miso_oe), 32'd0);
        check("m2_busy_desel", 32'(busy),    32'd0);
        ss_n = 1'b0;
        tick(8);
        xfer(8'h5A, 8, mi1);
        tick(8);
        check("m2_rx_count", 32'(rx_cnt - rx_base), 32'd1);
        check("m2_rx_data",  32'(rx_data), 32'h5A);
        ss_n = 1'b1;
        tick(8);

        // Reset mid-word, then stay disabled with ss_n low
        cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
        tick(4);
        tx_write(8'h55);
        ss_n = 1'b0;
        tick(8);
        xfer(8'hAA, 3, mi1);
        spi_en = 1'b0;
        reset = 1'b1;
        tick(1);
        check("rm_tx_ready", 32'(tx_ready), 32'd1);
        check("rm_busy",     32'(busy),     32'd0);
        check("rm_oe",       32'(miso_oe),  32'd0);
        check("rm_miso",     32'(miso),     32'd0);
        check("rm_rx_data",  32'(rx_data),  32'd0);
        check("rm_rx_valid", 32'(rx_valid), 32'd0);
        check("rm_underrun", 32'(underrun), 32'd0);
        tick(2);
        reset = 1'b0;
        rx_base = rx_cnt; busy_base = busy_cnt;
        tick(4);
        xfer(8'hC3, 8, mi1);
        tick(8);
        check("dis_busy_cycles", 32'(busy_cnt - busy_base), 32'd0);
        check("dis_rx_count",    32'(rx_cnt - rx_base), 32'd0);
        check("dis_oe",          32'(miso_oe), 32'd0);
        check("dis_tx_ready",    32'(tx_ready), 32'd1);
        ss_n = 1'b1;
        spi_en = 1'b1;
        tick(8);

`ifdef SPI_SLAVE_LSB_FIRST_EN
        // LSB-first, mode 0: preload 0x01, master sends 0x80 LSB first
        lsbfe = 1'b1;
        tx_write(8'h01);
        rx_base = rx_cnt;
        ss_n = 1'b0;
        tick(8);
        // 0x80 sent LSB first is the bit-reversed byte 0x01 through the MSB-first task.
        xfer(8'h01, 8, mi1);
        tick(8);
        check("lsb_miso_first", 32'(mi1[7]), 32'd1);
        check("lsb_miso_word",  32'(mi1), 32'h80);
        check("lsb_rx_count",   32'(rx_cnt - rx_base), 32'd1);
        check("lsb_rx_data",    32'(rx_data), 32'h80);
        ss_n = 1'b1;
        tick(8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
